pipe_hazard_ctrl: RTL and testbench

Stall/flush scheduler for the 5-stage MIPS pipeline. It decides each cycle whether the ID stage advances, which covers three cases:
- load-use hazards against the EX stage;
- taken-branch flushes of IF;
- structural and data hazards on the multi-cycle multiply/divide unit (MDU).

It also sequences the MDU and launches each operation. It drives the PC/IF-ID write enable, the ID/EX bubble select and the MDU launch.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/mdu_seq.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 73 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and MDU sequencer.
// Pure declarations: no logic, no latency, no flow control.
package pipe_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MDU_CYCLES_DEF = 32;
    localparam int         MDU_CNT_W      = 8;

endpackage

// File: rtl/mdu_seq.sv
// MDU occupancy sequencer: tracks one multiply/divide operation for MDU_CYCLES cycles.
// Busy rises the cycle after Go is sampled and stays high for exactly MDU_CYCLES cycles.
// No backpressure of its own: the caller must not pulse Go while Busy is high.
module mdu_seq
    import pipe_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Clrn,
    input  logic Go,
    output logic Busy
);

    localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_CYCLES - 1);

    mdu_state_t           r_state;
    logic [MDU_CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Go) begin
                        r_state <= BUSY;
                        r_cnt   <= LOAD_VAL;
                    end
                end
                BUSY: begin
                    // Counter reaches zero in the last busy cycle.
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Busy = (r_state == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, branch flush and MDU hazards.
// Zero latency: all outputs are combinational from ID/EX fields and the registered MDU state.
// Stalls hold PC and IF/ID and bubble ID/EX; HAZARD_PERF_CNT_EN adds a saturating Stall_Cnt.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        ID_UseHiLo,
    input  logic        ID_MduStart,
    input  logic        Branch_Taken,
    input  logic        EX_Wreg,
    input  logic        EX_M2reg,
    input  logic [4:0]  EX_Rd,
    output logic        Wpcir,
    output logic        Bubble,
    output logic        IF_Flush,
    output logic        Mdu_Go,
    output logic        Mdu_Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    logic w_ld_haz;
    logic w_mdu_haz;
    logic w_stall;
    logic w_mdu_busy;

    assign w_ld_haz = EX_Wreg & EX_M2reg & (EX_Rd != REG_ZERO) &
                      ((ID_UseRs & (ID_Rs == EX_Rd)) | (ID_UseRt & (ID_Rt == EX_Rd)));

    assign w_mdu_haz = w_mdu_busy & (ID_UseHiLo | ID_MduStart);
    assign w_stall   = w_ld_haz | w_mdu_haz;

    // A stalled branch is dropped here and re-resolved when ID finally advances.
    assign Wpcir    = ~w_stall;
    assign Bubble   = w_stall;
    assign IF_Flush = Branch_Taken & ~w_stall;
    assign Mdu_Go   = ID_MduStart & ~w_stall;
    assign Mdu_Busy = w_mdu_busy;

    mdu_seq #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu_seq (
        .Clk  (Clk),
        .Clrn (Clrn),
        .Go   (Mdu_Go),
        .Busy (w_mdu_busy)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign Stall_Cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with MDU_CYCLES=4.
module tb_pipe_hazard_ctrl;

    localparam int N = 4;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rd;
    logic        ID_UseRs, ID_UseRt, ID_UseHiLo, ID_MduStart, Branch_Taken;
    logic        EX_Wreg, EX_M2reg;
    logic        Wpcir, Bubble, IF_Flush, Mdu_Go, Mdu_Busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Cnt;
`endif

    int errs = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(.MDU_CYCLES(N)) dut (
        .Clk          (Clk),
        .Clrn         (Clrn),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UseRs     (ID_UseRs),
        .ID_UseRt     (ID_UseRt),
        .ID_UseHiLo   (ID_UseHiLo),
        .ID_MduStart  (ID_MduStart),
        .Branch_Taken (Branch_Taken),
        .EX_Wreg      (EX_Wreg),
        .EX_M2reg     (EX_M2reg),
        .EX_Rd        (EX_Rd),
        .Wpcir        (Wpcir),
        .Bubble       (Bubble),
        .IF_Flush     (IF_Flush),
        .Mdu_Go       (Mdu_Go),
        .Mdu_Busy     (Mdu_Busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Stall_Cnt    (Stall_Cnt)
`endif
    );

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic use_rs, use_rt, hilo, mstart, br, wreg, m2reg;
        logic e_wpcir, e_bubble, e_flush, e_go;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic use_rs, logic use_rt,
                                logic mstart, logic br, logic wreg, logic m2reg, logic [4:0] rd,
                                logic e_wpcir, logic e_bubble, logic e_flush, logic e_go);
        vec_t v;
        v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt; v.hilo = 1'b0;
        v.mstart = mstart; v.br = br; v.wreg = wreg; v.m2reg = m2reg; v.rd = rd;
        v.e_wpcir = e_wpcir; v.e_bubble = e_bubble; v.e_flush = e_flush; v.e_go = e_go;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        ID_Rs = '0; ID_Rt = '0; EX_Rd = '0;
        ID_UseRs = 0; ID_UseRt = 0; ID_UseHiLo = 0; ID_MduStart = 0; Branch_Taken = 0;
        EX_Wreg = 0; EX_M2reg = 0;
    endtask

    task automatic set_ld(input logic [4:0] rd);
        EX_Wreg = 1; EX_M2reg = 1; EX_Rd = rd; ID_UseRs = 1; ID_Rs = rd;
    endtask

    // Compare all status outputs at the falling edge, then move past the next rising edge.
    task automatic expect5(input string nm, input logic w, input logic b, input logic f,
                           input logic g, input logic bz);
        @(negedge Clk);
        chk({nm, ".Wpcir"}, Wpcir, w);
        chk({nm, ".Bubble"}, Bubble, b);
        chk({nm, ".IF_Flush"}, IF_Flush, f);
        chk({nm, ".Mdu_Go"}, Mdu_Go, g);
        chk({nm, ".Mdu_Busy"}, Mdu_Busy, bz);
        @(posedge Clk); #1;
    endtask

    initial begin
        int rem;
        logic [31:0] mcnt;
        logic ld, mh, st, go, rst;

        clr_in();
        Clrn = 0;
        #12;
        chk("rst.Wpcir", Wpcir, 1'b1);
        chk("rst.Bubble", Bubble, 1'b0);
        chk("rst.Mdu_Busy", Mdu_Busy, 1'b0);
        ID_MduStart = 1; #1;
        chk("rst.Mdu_Go_follows", Mdu_Go, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst.Stall_Cnt", Stall_Cnt, 32'd0);
`endif
        ID_MduStart = 0;
        Clrn = 1;
        @(posedge Clk); #1;

        // Combinational vectors with the MDU idle.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(8, 0, 1, 0, 0, 0, 1, 1, 8,  0, 1, 0, 0));
        vecs.push_back(mk(0, 8, 0, 1, 0, 0, 1, 1, 8,  0, 1, 0, 0));
        vecs.push_back(mk(8, 0, 0, 0, 0, 0, 1, 1, 8,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0,  1, 0, 0, 0));
        vecs.push_back(mk(8, 0, 1, 0, 0, 0, 1, 0, 8,  1, 0, 0, 0));
        vecs.push_back(mk(8, 0, 1, 0, 0, 0, 0, 1, 8,  1, 0, 0, 0));
        vecs.push_back(mk(9, 0, 1, 0, 0, 0, 1, 1, 8,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(8, 0, 1, 0, 0, 1, 1, 1, 8,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1));
        vecs.push_back(mk(0, 31, 0, 1, 1, 1, 1, 1, 31, 0, 1, 0, 0));
        foreach (vecs[i]) begin
            ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; EX_Rd = vecs[i].rd;
            ID_UseRs = vecs[i].use_rs; ID_UseRt = vecs[i].use_rt; ID_UseHiLo = vecs[i].hilo;
            ID_MduStart = vecs[i].mstart; Branch_Taken = vecs[i].br;
            EX_Wreg = vecs[i].wreg; EX_M2reg = vecs[i].m2reg;
            @(negedge Clk);
            chk($sformatf("vec%0d.Wpcir", i), Wpcir, vecs[i].e_wpcir);
            chk($sformatf("vec%0d.Bubble", i), Bubble, vecs[i].e_bubble);
            chk($sformatf("vec%0d.IF_Flush", i), IF_Flush, vecs[i].e_flush);
            chk($sformatf("vec%0d.Mdu_Go", i), Mdu_Go, vecs[i].e_go);
            #1 clr_in();
            @(posedge Clk); #1;
        end

        // Load-use with a taken branch: one stall, then flush once the load moves on.
        set_ld(5'd8); Branch_Taken = 1;
        expect5("lu_stall", 0, 1, 0, 0, 0);
        EX_Wreg = 0; EX_M2reg = 0;
        expect5("lu_after", 1, 0, 1, 0, 0);
        clr_in();

        // mult then mflo waiting in ID.
        ID_MduStart = 1;
        expect5("mult_go", 1, 0, 0, 1, 0);
        ID_MduStart = 0; ID_UseHiLo = 1;
        for (int c = 1; c <= N; c++) expect5($sformatf("mflo_c%0d", c), 0, 1, 0, 0, 1);
        expect5("mflo_adv", 1, 0, 0, 0, 0);
        clr_in();

        // Back-to-back mults.
        ID_MduStart = 1;
        expect5("m1_go", 1, 0, 0, 1, 0);
        for (int c = 1; c <= N; c++) expect5($sformatf("m2_wait%0d", c), 0, 1, 0, 0, 1);
        expect5("m2_go", 1, 0, 0, 1, 0);
        ID_MduStart = 0;
        for (int c = 1; c <= N; c++) expect5($sformatf("m2_busy%0d", c), 1, 0, 0, 0, 1);
        expect5("m2_done", 1, 0, 0, 0, 0);

        // Reset during cycle 2 of a busy operation releases a waiting mflo.
        ID_MduStart = 1;
        expect5("rm_go", 1, 0, 0, 1, 0);
        ID_MduStart = 0; ID_UseHiLo = 1;
        expect5("rm_c1", 0, 1, 0, 0, 1);
        Clrn = 0; #1;
        chk("rm.Mdu_Busy", Mdu_Busy, 1'b0);
        chk("rm.Wpcir", Wpcir, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
        chk("rm.Stall_Cnt", Stall_Cnt, 32'd0);
`endif
        @(negedge Clk); Clrn = 1;
        @(posedge Clk); #1;
        expect5("rm_after", 1, 0, 0, 0, 0);
        clr_in();

`ifdef HAZARD_PERF_CNT_EN
        for (int k = 0; k < 3; k++) begin
            set_ld(5'd3);
            expect5("pc_ld", 0, 1, 0, 0, 0);
            clr_in();
            expect5("pc_gap", 1, 0, 0, 0, 0);
        end
        ID_MduStart = 1;
        expect5("pc_go", 1, 0, 0, 1, 0);
        ID_MduStart = 0; ID_UseHiLo = 1;
        for (int c = 1; c <= N; c++) expect5("pc_mdu", 0, 1, 0, 0, 1);
        clr_in();
        @(negedge Clk);
        chk("pc.Stall_Cnt7", Stall_Cnt, 32'd7);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_stall_cnt;
        @(posedge Clk); #1;
        for (int k = 0; k < 3; k++) begin
            set_ld(5'd4);
            expect5("pc_sat", 0, 1, 0, 0, 0);
        end
        clr_in();
        @(negedge Clk);
        chk("pc.Stall_Cnt_sat", Stall_Cnt, 32'hFFFF_FFFF);
        @(posedge Clk); #1;
`endif

        // Randomized run against a cycle-level model of the stated rules.
        rem = 0;
        mcnt = 0;
        for (int it = 0; it < 1500; it++) begin
            ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
            EX_Rd = 5'($urandom_range(0, 3));
            ID_UseRs = 1'($urandom); ID_UseRt = 1'($urandom);
            ID_UseHiLo = ($urandom_range(0, 3) == 0); ID_MduStart = ($urandom_range(0, 3) == 0);
            Branch_Taken = 1'($urandom); EX_Wreg = 1'($urandom); EX_M2reg = 1'($urandom);
            rst = (it == 0) || ($urandom_range(0, 59) == 0);
            if (rst) begin
                Clrn = 0; #1;
                rem = 0; mcnt = 0;
            end
            ld = EX_Wreg && EX_M2reg && (EX_Rd != 0) &&
                 ((ID_UseRs && ID_Rs == EX_Rd) || (ID_UseRt && ID_Rt == EX_Rd));
            mh = (rem > 0) && (ID_UseHiLo || ID_MduStart);
            st = ld || mh;
            go = ID_MduStart && !st;
            @(negedge Clk);
            chk("rnd.Wpcir", Wpcir, !st);
            chk("rnd.Bubble", Bubble, st);
            chk("rnd.IF_Flush", IF_Flush, Branch_Taken && !st);
            chk("rnd.Mdu_Go", Mdu_Go, go);
            chk("rnd.Mdu_Busy", Mdu_Busy, rem > 0);
`ifdef HAZARD_PERF_CNT_EN
            chk("rnd.Stall_Cnt", Stall_Cnt, mcnt);
`endif
            if (rst) Clrn = 1;
            @(posedge Clk);
            if (rem > 0) rem--;
            if (go) rem = N;
            if (st && mcnt != 32'hFFFF_FFFF) mcnt++;
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
